// File: rtl/host_rx_if.sv
// Pin bundle between the ESP32 nibble port and the register framer.
// The master side drives chunks and strobes; the slave side returns commits, errors and the register bank.
interface host_rx_if #(
  parameter int NIB_W = 4,
  parameter int N_NIB = 3,
  parameter int N_REG = 4
);
  localparam int DATA_W = NIB_W * N_NIB;
  localparam int ADDR_W = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int PH_W   = $clog2(N_NIB + 1);

  logic [NIB_W-1:0]        DataIn;
  logic [PH_W-1:0]         ReadPhase;
  logic                    ReadPulse;
  logic [DATA_W-1:0]       DataOut;
  logic [ADDR_W-1:0]       DataAddr;
  logic                    DataOutValid;
  logic [N_REG*DATA_W-1:0] RegData;
  logic                    FrameErr;
  logic [1:0]              ErrCode;
  logic                    Busy;

  modport master (
    output DataIn, ReadPhase, ReadPulse,
    input  DataOut, DataAddr, DataOutValid, RegData, FrameErr, ErrCode, Busy
  );

  modport slave (
    input  DataIn, ReadPhase, ReadPulse,
    output DataOut, DataAddr, DataOutValid, RegData, FrameErr, ErrCode, Busy
  );
endinterface

// File: rtl/host_rx_framer.sv
// Assembles strobed nibbles into words and writes them to a small control-register bank.
// Adds phase-order checking, an inter-strobe timeout and sticky error reporting.
module host_rx_framer #(
  parameter int NIB_W       = 4,
  parameter int N_NIB       = 3,
  parameter int N_REG       = 4,
  parameter int TIMEOUT     = 1023,
  parameter int SYNC_STAGES = 2
) (
  input logic      ExtClk,
  input logic      ExtReset,
  host_rx_if.slave bus
);
  localparam int DATA_W   = NIB_W * N_NIB;
  localparam int ADDR_W   = (N_REG > 1) ? $clog2(N_REG) : 1;
  localparam int PH_W     = $clog2(N_NIB + 1);
  localparam int TMR_W    = $clog2(TIMEOUT + 1);
  // FrameErr is registered, so the decision is taken early to land TIMEOUT cycles after the edge.
  localparam int TMO_LAST = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

  typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    pulse_q;
  logic                    edge_q;

  state_t                  state_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [PH_W-1:0]         exp_q;
  logic [TMR_W-1:0]        timer_q;
  logic [DATA_W-1:0]       word_q;
  logic [N_REG*DATA_W-1:0] regdata_q;
  logic [DATA_W-1:0]       dout_q;
  logic [ADDR_W-1:0]       daddr_q;
  logic                    valid_q;
  logic                    ferr_q;
  logic [1:0]              ecode_q;

  logic [ADDR_W-1:0]       new_addr;
  logic                    addr_ok;
  logic                    phase0;
  logic                    slot_ok;
  logic                    last_slot;
  logic                    tmo;
  logic [DATA_W-1:0]       word_d;
  logic [N_REG*DATA_W-1:0] regdata_d;

  always_ff @(posedge ExtClk or posedge ExtReset) begin
    if (ExtReset) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.ReadPulse};
      pulse_q <= sync_q[SYNC_STAGES-1];
      edge_q  <= sync_q[SYNC_STAGES-1] & ~pulse_q;
    end
  end

  always_comb begin
    new_addr  = bus.DataIn[ADDR_W-1:0];
    addr_ok   = ({1'b0, new_addr} < (ADDR_W+1)'(N_REG)) && ((bus.DataIn >> ADDR_W) == '0);
    phase0    = (bus.ReadPhase == '0);
    slot_ok   = (bus.ReadPhase == exp_q);
    last_slot = (exp_q == PH_W'(N_NIB));
    tmo       = (timer_q == TMR_W'(TMO_LAST));
    // Slot 1 is the most significant nibble.
    word_d = word_q;
    for (int s = 1; s <= N_NIB; s++) begin
      if (exp_q == PH_W'(s)) word_d[(N_NIB-s)*NIB_W +: NIB_W] = bus.DataIn;
    end
    regdata_d = regdata_q;
    for (int r = 0; r < N_REG; r++) begin
      if (addr_q == ADDR_W'(r)) regdata_d[r*DATA_W +: DATA_W] = word_d;
    end
  end

  always_ff @(posedge ExtClk or posedge ExtReset) begin
    if (ExtReset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      exp_q     <= '0;
      timer_q   <= '0;
      word_q    <= '0;
      regdata_q <= '0;
      dout_q    <= '0;
      daddr_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ecode_q   <= 2'd0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (edge_q) begin
            if (!phase0) begin
              ferr_q  <= 1'b1;
              ecode_q <= 2'd1;
            end else if (!addr_ok) begin
              ferr_q  <= 1'b1;
              ecode_q <= 2'd3;
            end else begin
              addr_q  <= new_addr;
              exp_q   <= PH_W'(1);
              word_q  <= '0;
              state_q <= RECV;
            end
          end
        end
        RECV: begin
          if (edge_q) begin
            timer_q <= '0;
            if (slot_ok) begin
              word_q <= word_d;
              if (last_slot) begin
                regdata_q <= regdata_d;
                dout_q    <= word_d;
                daddr_q   <= addr_q;
                valid_q   <= 1'b1;
                state_q   <= COMMIT;
              end else begin
                exp_q <= exp_q + PH_W'(1);
              end
            end else if (phase0) begin
              // Restart on the same edge; a bad new address outranks the sequence error.
              ferr_q <= 1'b1;
              if (addr_ok) begin
                ecode_q <= 2'd1;
                addr_q  <= new_addr;
                exp_q   <= PH_W'(1);
                word_q  <= '0;
              end else begin
                ecode_q <= 2'd3;
                state_q <= IDLE;
              end
            end else begin
              ferr_q  <= 1'b1;
              ecode_q <= 2'd1;
              state_q <= IDLE;
            end
          end else if (tmo) begin
            ferr_q  <= 1'b1;
            ecode_q <= 2'd2;
            timer_q <= '0;
            state_q <= IDLE;
          end else if (timer_q != TMR_W'(TIMEOUT)) begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        COMMIT: begin
          timer_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.DataOut      = dout_q;
  assign bus.DataAddr     = daddr_q;
  assign bus.DataOutValid = valid_q;
  assign bus.RegData      = regdata_q;
  assign bus.FrameErr     = ferr_q;
  assign bus.ErrCode      = ecode_q;
  assign bus.Busy         = (state_q != IDLE);
endmodule

// File: tb/tb_host_rx_framer.sv
// Directed bench for host_rx_framer: a table of whole frames with hand-computed results,
// followed by timeout, same-edge restart and asynchronous reset sequences.
module tb_host_rx_framer;
  logic clk;
  logic rst;
  int   cyc;

  host_rx_if #(.NIB_W(4), .N_NIB(3), .N_REG(4)) bus ();

  host_rx_framer #(
    .NIB_W(4), .N_NIB(3), .N_REG(4), .TIMEOUT(16), .SYNC_STAGES(2)
  ) dut (
    .ExtClk  (clk),
    .ExtReset(rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][1:0]  ph;
    logic [3:0][3:0]  d;
    logic             ev;
    logic             ee;
    logic [1:0]       ec;
    logic [11:0]      ew;
    logic [1:0]       ea;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int n_vec;
  int n_bad;
  int last_rise;
  int tot_valid;
  int tot_err;
  int ferr_cyc;
  int overlap_cnt;
  logic busy_at_ferr;
  logic busy_pre_ferr;
  logic prev_busy;

  logic [47:0] m_reg;
  logic [11:0] m_dout;
  logic [1:0]  m_addr;
  logic [1:0]  m_code;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tot_valid = 0; tot_err = 0; ferr_cyc = -1; overlap_cnt = 0;
    busy_at_ferr = 1'b0; busy_pre_ferr = 1'b0; prev_busy = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.DataOutValid) tot_valid++;
      if (bus.FrameErr) begin
        tot_err++;
        ferr_cyc      = cyc;
        busy_at_ferr  = bus.Busy;
        busy_pre_ferr = prev_busy;
      end
      if (bus.DataOutValid && bus.FrameErr) overlap_cnt++;
    end
    prev_busy = bus.Busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int n, input int p0, input int d0, input int p1, input int d1,
                              input int p2, input int d2, input int p3, input int d3,
                              input int ev, input int ee, input int ec, input int ew, input int ea);
    vec_t v;
    v.n = 3'(n);
    v.ph[0] = 2'(p0); v.d[0] = 4'(d0);
    v.ph[1] = 2'(p1); v.d[1] = 4'(d1);
    v.ph[2] = 2'(p2); v.d[2] = 4'(d2);
    v.ph[3] = 2'(p3); v.d[3] = 4'(d3);
    v.ev = 1'(ev); v.ee = 1'(ee); v.ec = 2'(ec); v.ew = 12'(ew); v.ea = 2'(ea);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic [1:0] ph, input logic [3:0] d);
    @(posedge clk);
    #1;
    bus.DataIn    = d;
    bus.ReadPhase = ph;
    bus.ReadPulse = 1'b1;
    last_rise     = cyc;
    repeat (4) @(posedge clk);
    #1;
    bus.ReadPulse = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_err_code"}, 64'(bus.ErrCode), 64'(m_code));
    chk({tag, "_dout"},     64'(bus.DataOut), 64'(m_dout));
    chk({tag, "_daddr"},    64'(bus.DataAddr), 64'(m_addr));
    chk({tag, "_regdata"},  64'(bus.RegData), 64'(m_reg));
    chk({tag, "_busy"},     64'(bus.Busy), 64'd0);
  endtask

  initial begin
    int v0, e0, k;
    n_vec = 0; n_bad = 0; last_rise = 0;
    m_reg = '0; m_dout = '0; m_addr = '0; m_code = '0;

    vecs[0] = mk(4, 0,'h2, 1,'hA, 2,'h5, 3,'hC, 1,0,0,'hA5C,2);
    vecs[1] = mk(3, 0,'h1, 1,'h3, 3,'h7, 0,0,   0,1,1,0,0);
    vecs[2] = mk(4, 0,'h1, 1,'hB, 2,'hE, 3,'h4, 1,0,0,'hBE4,1);
    vecs[3] = mk(1, 0,'h5, 0,0,   0,0,   0,0,   0,1,3,0,0);
    vecs[4] = mk(1, 0,'h9, 0,0,   0,0,   0,0,   0,1,3,0,0);
    vecs[5] = mk(1, 2,'h7, 0,0,   0,0,   0,0,   0,1,1,0,0);
    vecs[6] = mk(4, 0,'h3, 1,'hF, 2,'hF, 3,'hF, 1,0,0,'hFFF,3);
    vecs[7] = mk(4, 0,'h0, 1,'h0, 2,'h1, 3,'h0, 1,0,0,'h010,0);
    vecs[8] = mk(2, 0,'h2, 2,'h6, 0,0,   0,0,   0,1,1,0,0);
    vecs[9] = mk(1, 0,'h4, 0,0,   0,0,   0,0,   0,1,3,0,0);

    rst = 1'b1;
    bus.DataIn = '0; bus.ReadPhase = '0; bus.ReadPulse = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dout",    64'(bus.DataOut), 64'd0);
    chk("rst_regdata", 64'(bus.RegData), 64'd0);
    chk("rst_flags",   64'({bus.DataOutValid, bus.FrameErr, bus.Busy, bus.ErrCode}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      v0 = tot_valid; e0 = tot_err;
      for (int j = 0; j < int'(vecs[i].n); j++) pulse(vecs[i].ph[j], vecs[i].d[j]);
      settle();
      if (vecs[i].ev) begin
        m_reg[int'(vecs[i].ea)*12 +: 12] = vecs[i].ew;
        m_dout = vecs[i].ew;
        m_addr = vecs[i].ea;
      end
      if (vecs[i].ee) m_code = vecs[i].ec;
      chk($sformatf("v%0d_valid_cnt", i), 64'(tot_valid - v0), 64'(vecs[i].ev));
      chk($sformatf("v%0d_err_cnt", i), 64'(tot_err - e0), 64'(vecs[i].ee));
      chk_outputs($sformatf("v%0d", i));
    end

    // Timeout: error lands exactly 16 cycles after the phase-1 edge cycle.
    v0 = tot_valid; e0 = tot_err;
    pulse(2'd0, 4'h0);
    pulse(2'd1, 4'h4);
    k = last_rise + 3;
    for (int t = 0; t < 40 && tot_err == e0; t++) @(negedge clk);
    chk("tmo_seen", 64'(tot_err - e0), 64'd1);
    chk("tmo_cycle", 64'(ferr_cyc - k), 64'd16);
    chk("tmo_busy_pre", 64'(busy_pre_ferr), 64'd1);
    chk("tmo_busy_at", 64'(busy_at_ferr), 64'd0);
    settle();
    m_code = 2'd2;
    chk("tmo_err_cnt", 64'(tot_err - e0), 64'd1);
    chk("tmo_valid_cnt", 64'(tot_valid - v0), 64'd0);
    chk_outputs("tmo");

    // Same-edge restart: abort one cycle after the second phase-0 edge, new frame still commits.
    v0 = tot_valid; e0 = tot_err;
    pulse(2'd0, 4'h1);
    pulse(2'd1, 4'hF);
    pulse(2'd0, 4'h3);
    k = last_rise + 3;
    pulse(2'd1, 4'h1);
    pulse(2'd2, 4'h2);
    pulse(2'd3, 4'h3);
    settle();
    m_reg[36 +: 12] = 12'h123;
    m_dout = 12'h123; m_addr = 2'd3; m_code = 2'd1;
    chk("rs_err_cycle", 64'(ferr_cyc - k), 64'd1);
    chk("rs_busy_at", 64'(busy_at_ferr), 64'd1);
    chk("rs_err_cnt", 64'(tot_err - e0), 64'd1);
    chk("rs_valid_cnt", 64'(tot_valid - v0), 64'd1);
    chk_outputs("rs");

    // Async reset in the middle of a frame.
    pulse(2'd0, 4'h2);
    pulse(2'd1, 4'hA);
    pulse(2'd2, 4'h5);
    @(posedge clk);
    #3;
    chk("ar_busy_before", 64'(bus.Busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("ar_dout",    64'(bus.DataOut), 64'd0);
    chk("ar_daddr",   64'(bus.DataAddr), 64'd0);
    chk("ar_regdata", 64'(bus.RegData), 64'd0);
    chk("ar_flags",   64'({bus.DataOutValid, bus.FrameErr, bus.Busy, bus.ErrCode}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m_reg = '0; m_dout = '0; m_addr = '0; m_code = '0;
    v0 = tot_valid; e0 = tot_err;
    pulse(2'd0, 4'h2);
    pulse(2'd1, 4'hA);
    pulse(2'd2, 4'h5);
    pulse(2'd3, 4'hC);
    settle();
    m_reg[24 +: 12] = 12'hA5C;
    m_dout = 12'hA5C; m_addr = 2'd2;
    chk("ar_valid_cnt", 64'(tot_valid - v0), 64'd1);
    chk("ar_err_cnt", 64'(tot_err - e0), 64'd0);
    chk("ar_regdata_after", 64'(bus.RegData), 64'h000A5C000000);
    chk_outputs("ar");

    chk("no_overlap", 64'(overlap_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
